sgdmac_axi_mem_slave: RTL and testbench
=======================================

Name: sgdmac_axi_mem_slave

Overview:
AXI3 slave memory that answers the bus requests issued by the SGDMAC: the descriptor fetcher and data reader on AR/R, and the data writer on AW/W/B. It serves as the DMA's system-memory target in the SoC subsystem and top-level testbench. It has one word-addressed SRAM array with independent read and write engines, one outstanding burst per direction, and SLVERR on bad accesses.

Parameters:
MEM_DEPTH, 4096, number of 32-bit words in the array
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
AW: awid_i in 4, awaddr_i in 32, awlen_i in 4, awsize_i in 3, awburst_i in 2, awvalid_i in 1, awready_o out 1
W: wid_i in 4, wdata_i in 32, wstrb_i in 4, wlast_i in 1, wvalid_i in 1, wready_o out 1
B: bid_o out 4, bresp_o out 2, bvalid_o out 1, bready_i in 1
AR: arid_i in 4, araddr_i in 32, arlen_i in 4, arsize_i in 3, arburst_i in 2, arvalid_i in 1, arready_o out 1
R: rid_o out 4, rdata_o out 32, rresp_o out 2, rlast_o out 1, rvalid_o out 1, rready_i in 1

Behaviour:
- Reset values: awready_o=1, arready_o=1 (both engines IDLE). All other outputs are 0. Memory contents are not reset.
- Reset mid-burst: the burst is aborted and both FSMs return to IDLE. Beats already written stay in memory, and no B or R response is issued for the aborted burst.
- Beat address: word index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
  - INCR (2'b01): +4 bytes per beat.
  - FIXED (2'b00): the address is constant.
  - WRAP (2'b10) or RSVD: the burst is flagged bad.
  - A beat is bad if addr < BASE_ADDR, index >= MEM_DEPTH, or size != 3'd2.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: awready_o=1. On AW handshake, latch id, addr, len and burst, clear the beat counter and the error flag, then go to W_DATA.
  - W_DATA: wready_o=1. Each W handshake writes the bytes enabled by wstrb_i if the beat is good; a bad beat sets the error flag and is dropped. The beat counter then increments.
  - W_DATA exits on a handshake with wlast_i=1. If wlast_i arrives with counter != len, or no wlast_i arrives by beat len, the error flag is set. Beats after beat len are accepted but not written, until wlast_i.
  - W_RESP: bvalid_o=1, bid_o=latched awid, bresp_o = 2'b10 if error else 2'b00. Hold until bready_i, then go to W_IDLE.
  - wid_i is ignored.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: arready_o=1. On AR handshake, latch id, len and burst. rdata_o is registered and loaded with mem[beat0] (or 0 if the beat is bad). rvalid_o=1 on the next cycle.
  - R_DATA: rid_o=latched id. rresp_o = 2'b10 for a bad beat, else 2'b00. rlast_o = (counter == len).
  - rdata_o, rresp_o and rlast_o hold stable while rvalid_o & ~rready_i.
  - On an R handshake that is not the last beat, load the next beat's data, with no bubble (one beat per cycle).
  - On the last beat's handshake, go to R_IDLE: rvalid_o=0 and arready_o=1 on the next cycle.
- Read and write engines run concurrently. A write and a read-data load of the same word in the same cycle: the read captures the old data.
- Latency: AR handshake to first rvalid is 1 cycle. Last W beat to bvalid is 1 cycle.
- Bursts: at most one outstanding burst per direction, max length 16 beats. The engines never accept a new AW/AR before completing the current response.

Test Plan:
- Write INCR awaddr=0x100, len=3, data 0xA0..0xA3, wstrb=4'hF, then read the same range -> bresp=00, bid echoes awid=2, rdata A0,A1,A2,A3 with rlast on beat 3 and rid echoes arid.
- Partial strobe: mem[0x40]=0x11223344, write 0xAABBCCDD with wstrb=4'b0101 -> readback 0x11BB33DD.
- Out of range: awaddr=BASE+MEM_DEPTH*4, len=0 -> bresp=10 and memory unchanged. The matching read -> rresp=10, rdata=0.
- Back-pressure: read len=7 with rready_i toggled every other cycle -> 8 beats, in order and stable while stalled, rlast only on the 8th beat. bready_i held low for 5 cycles -> bvalid stays high and awready stays low.
- wlast on beat 1 of a len=3 burst -> bresp=10. Concurrent AR/AW to the same word in the same cycle -> read returns the pre-write value.
- Assert rst during beat 2 of a len=7 read -> rvalid=0 immediately. After release: arready=1, awready=1, and a new burst completes normally.

Source files
------------

// File: rtl/sgdmac_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : sgdmac_axi_mem_slave
// Purpose  : AXI3 slave memory serving the SGDMAC descriptor fetcher / data
//            reader (AR/R) and data writer (AW/W/B). One word-addressed SRAM
//            array with independent read and write engines, one outstanding
//            burst per direction, SLVERR on bad beats.
// Ports    : clk, rst (async, active high)
//            AW/W/B : write address, write data, write response channels
//            AR/R   : read address, read data channels
// Revision : 1.0 - initial release
// ============================================================================
module sgdmac_axi_mem_slave #(
  parameter int          MEM_DEPTH = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam int         c_idx_w     = $clog2(MEM_DEPTH);
  localparam logic [1:0] c_resp_okay = 2'b00;
  localparam logic [1:0] c_resp_slv  = 2'b10;
  localparam logic [1:0] c_burst_inc = 2'b01;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // Below-base detection uses the borrow of a 33-bit subtraction.
  function automatic logic addr_bad(input logic [31:0] addr);
    logic [32:0] diff;
    diff = {1'b0, addr} - {1'b0, BASE_ADDR};
    return diff[32] || ((diff[31:0] >> 2) >= 32'(MEM_DEPTH));
  endfunction

  // Only 32-bit beats with FIXED or INCR bursts are served.
  function automatic logic cfg_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd2) || burst[1];
  endfunction

  logic [31:0] r_mem [MEM_DEPTH];

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------
  wstate_t     r_wstate, w_wstate_nxt;
  logic [3:0]  r_wid;
  logic [31:0] r_waddr;
  logic [3:0]  r_wlen;
  logic [3:0]  r_wcnt;
  logic        r_wcfg_bad;
  logic        r_wincr;
  logic        r_werr;
  logic        r_wover;   // beat len passed without wlast: drop until wlast

  logic        w_aw_hs, w_w_hs, w_wbeat_bad, w_wr_en;
  logic [31:0] w_widx_full;
  logic [c_idx_w-1:0] w_widx;

  assign w_aw_hs     = awvalid_i & awready_o;
  assign w_w_hs      = wvalid_i & wready_o;
  assign w_wbeat_bad = r_wcfg_bad | addr_bad(r_waddr);
  assign w_wr_en     = w_w_hs & ~w_wbeat_bad & ~r_wover;
  assign w_widx_full = (r_waddr - BASE_ADDR) >> 2;
  assign w_widx      = w_widx_full[c_idx_w-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    awready_o    = 1'b0;
    wready_o     = 1'b0;
    bvalid_o     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        awready_o = 1'b1;
        if (awvalid_i) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i && wlast_i) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wid      <= '0;
      r_waddr    <= '0;
      r_wlen     <= '0;
      r_wcnt     <= '0;
      r_wcfg_bad <= 1'b0;
      r_wincr    <= 1'b0;
      r_werr     <= 1'b0;
      r_wover    <= 1'b0;
    end else if (w_aw_hs) begin
      r_wid      <= awid_i;
      r_waddr    <= awaddr_i;
      r_wlen     <= awlen_i;
      r_wcnt     <= '0;
      r_wcfg_bad <= cfg_bad(awsize_i, awburst_i);
      r_wincr    <= (awburst_i == c_burst_inc);
      r_werr     <= 1'b0;
      r_wover    <= 1'b0;
    end else if (w_w_hs) begin
      r_wcnt <= r_wcnt + 4'd1;
      if (r_wincr) r_waddr <= r_waddr + 32'd4;
      if (w_wbeat_bad) r_werr <= 1'b1;
      if (wlast_i) begin
        if (r_wover || (r_wcnt != r_wlen)) r_werr <= 1'b1;
      end else if (!r_wover && (r_wcnt == r_wlen)) begin
        r_wover <= 1'b1;
        r_werr  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) r_mem[w_widx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign bid_o   = r_wid;
  assign bresp_o = r_werr ? c_resp_slv : c_resp_okay;

  // --------------------------------------------------------------------------
  // Read engine: r_raddr always holds the address of the next beat to load,
  // so a beat is prefetched on every handshake and the bus sees no bubble.
  // --------------------------------------------------------------------------
  rstate_t     r_rstate, w_rstate_nxt;
  logic [3:0]  r_rid;
  logic [31:0] r_raddr;
  logic [3:0]  r_rlen;
  logic [3:0]  r_rcnt;
  logic        r_rcfg_bad;
  logic        r_rincr;
  logic [31:0] r_rdata;
  logic        r_rbad;

  logic        w_ar_hs, w_r_hs, w_rlast;
  logic        w_rld_en, w_rld_bad, w_rld_incr;
  logic [31:0] w_rld_addr, w_ridx_full;
  logic [c_idx_w-1:0] w_ridx;

  assign w_ar_hs     = arvalid_i & arready_o;
  assign w_r_hs      = rvalid_o & rready_i;
  assign w_rlast     = (r_rcnt == r_rlen);
  assign w_rld_en    = w_ar_hs | (w_r_hs & ~w_rlast);
  assign w_rld_addr  = (r_rstate == R_IDLE) ? araddr_i : r_raddr;
  assign w_rld_incr  = (r_rstate == R_IDLE) ? (arburst_i == c_burst_inc) : r_rincr;
  assign w_rld_bad   = ((r_rstate == R_IDLE) ? cfg_bad(arsize_i, arburst_i) : r_rcfg_bad)
                       | addr_bad(w_rld_addr);
  assign w_ridx_full = (w_rld_addr - BASE_ADDR) >> 2;
  assign w_ridx      = w_ridx_full[c_idx_w-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    arready_o    = 1'b0;
    rvalid_o     = 1'b0;
    rlast_o      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        arready_o = 1'b1;
        if (arvalid_i) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        rlast_o  = w_rlast;
        if (rready_i && w_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // The array read here sees the pre-write word when a write hits the same
  // index in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rid      <= '0;
      r_raddr    <= '0;
      r_rlen     <= '0;
      r_rcnt     <= '0;
      r_rcfg_bad <= 1'b0;
      r_rincr    <= 1'b0;
      r_rdata    <= '0;
      r_rbad     <= 1'b0;
    end else begin
      if (w_rld_en) begin
        r_rdata <= w_rld_bad ? 32'd0 : r_mem[w_ridx];
        r_rbad  <= w_rld_bad;
        r_raddr <= w_rld_incr ? (w_rld_addr + 32'd4) : w_rld_addr;
      end
      if (w_ar_hs) begin
        r_rid      <= arid_i;
        r_rlen     <= arlen_i;
        r_rcnt     <= '0;
        r_rcfg_bad <= cfg_bad(arsize_i, arburst_i);
        r_rincr    <= (arburst_i == c_burst_inc);
      end else if (w_r_hs) begin
        r_rcnt <= r_rcnt + 4'd1;
      end
    end
  end

  assign rid_o   = r_rid;
  assign rdata_o = r_rdata;
  assign rresp_o = r_rbad ? c_resp_slv : c_resp_okay;

  // wid_i carries no information for a single-outstanding slave.
  logic w_unused;
  assign w_unused = &{1'b0, wid_i, w_widx_full[31:c_idx_w], w_ridx_full[31:c_idx_w]};

endmodule
`default_nettype wire

// File: tb/tb_sgdmac_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgdmac_axi_mem_slave
// Purpose  : Self-checking bench for sgdmac_axi_mem_slave. A word model of the
//            array produces expected R beats and B responses that are queued
//            when stimulus is driven and popped when the DUT responds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sgdmac_axi_mem_slave;

  localparam int          MEM_DEPTH = 4096;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          TMO       = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid;   logic [31:0] awaddr; logic [3:0] awlen;
  logic [2:0]  awsize; logic [1:0]  awburst; logic awvalid; logic awready;
  logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb;
  logic        wlast;  logic wvalid; logic wready;
  logic [3:0]  bid;    logic [1:0] bresp; logic bvalid; logic bready;
  logic [3:0]  arid;   logic [31:0] araddr; logic [3:0] arlen;
  logic [2:0]  arsize; logic [1:0]  arburst; logic arvalid; logic arready;
  logic [3:0]  rid;    logic [31:0] rdata; logic [1:0] rresp;
  logic        rlast;  logic rvalid; logic rready;

  sgdmac_axi_mem_slave #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
    .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
    .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .rvalid_o(rvalid), .rready_i(rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] model [MEM_DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic beat_ok(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    return (a >= BASE) && (((a - BASE) >> 2) < 32'(MEM_DEPTH)) && (size == 3'd2) && !burst[1];
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin n_checks++; n_errors++; $display("FAIL aw_timeout got awready=%b want 1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin n_checks++; n_errors++; $display("FAIL ar_timeout got arready=%b want 1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic send_w(input int nbeats, input logic [31:0] data0, input logic [3:0] strb);
    for (int i = 0; i < nbeats; i++) begin
      int t = 0;
      wdata = data0 + 32'(i); wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
      while (wready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin n_checks++; n_errors++; $display("FAIL w_timeout beat %0d got wready=%b want 1", i, wready); end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic collect_b(input int stall);
    int    t = 0;
    bexp_t e;
    bready = 1'b0;
    while (bvalid !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin n_checks++; n_errors++; $display("FAIL b_timeout got bvalid=%b want 1", bvalid); end
    for (int k = 0; k < stall; k++) begin
      n_checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        n_errors++; $display("FAIL b_hold cycle %0d got bvalid=%b awready=%b want 1 0", k, bvalid, awready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    n_checks++;
    if (bq.size() == 0) begin
      n_errors++; $display("FAIL b_resp got unexpected response want none queued");
    end else begin
      e = bq.pop_front();
      if ({bid, bresp} !== {e.id, e.resp}) begin
        n_errors++; $display("FAIL b_resp got bid=%0d bresp=%b want bid=%0d bresp=%b", bid, bresp, e.id, e.resp);
      end
    end
    @(negedge clk);
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      n_errors++; $display("FAIL b_done got bvalid=%b awready=%b want 0 1", bvalid, awready);
    end
  endtask

  task automatic collect_r(input int n, input bit toggle, input bit check_end);
    int          got = 0;
    int          cyc = 0;
    bit          held = 1'b0;
    logic [38:0] snap = '0;
    rexp_t       e;
    while (got < n && cyc < 4 * TMO) begin
      rready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (rvalid === 1'b1) begin
        if (held) begin
          n_checks++;
          if ({rdata, rresp, rlast, rid} !== snap) begin
            n_errors++; $display("FAIL r_stable got %h want %h", {rdata, rresp, rlast, rid}, snap);
          end
          held = 1'b0;
        end
        if (rready) begin
          n_checks++;
          if (rq.size() == 0) begin
            n_errors++; $display("FAIL r_beat got unexpected beat data=%h want none queued", rdata);
          end else begin
            e = rq.pop_front();
            if ({rdata, rresp, rlast, rid} !== {e.data, e.resp, e.last, e.id}) begin
              n_errors++;
              $display("FAIL r_beat %0d got data=%h resp=%b last=%b id=%0d want data=%h resp=%b last=%b id=%0d",
                       got, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
            end
          end
          got++;
        end else begin
          held = 1'b1;
          snap = {rdata, rresp, rlast, rid};
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    if (got < n) begin n_checks++; n_errors++; $display("FAIL r_timeout got %0d beats want %0d", got, n); end
    if (check_end) begin
      n_checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
        n_errors++; $display("FAIL r_end got rvalid=%b arready=%b want 0 1", rvalid, arready);
      end
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int nbeats, input logic [31:0] data0, input logic [3:0] strb,
                          input logic [2:0] size, input logic [1:0] burst, input int stall);
    logic [31:0] a = addr;
    logic [31:0] d;
    bit          err = (nbeats != int'(len) + 1);
    bexp_t       e;
    for (int i = 0; i < nbeats; i++) begin
      if (!beat_ok(a, size, burst)) err = 1'b1;
      else if (i <= int'(len)) begin
        d = data0 + 32'(i);
        for (int b = 0; b < 4; b++) if (strb[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
      if (burst == 2'b01) a = a + 32'd4;
    end
    e.id = id; e.resp = err ? 2'b10 : 2'b00;
    bq.push_back(e);
    send_aw(id, addr, len, size, burst);
    send_w(nbeats, data0, strb);
    collect_b(stall);
  endtask

  task automatic queue_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a = addr;
    rexp_t       e;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id; e.last = (i == int'(len));
      if (beat_ok(a, size, burst)) begin e.data = model[widx(a)]; e.resp = 2'b00; end
      else begin e.data = 32'd0; e.resp = 2'b10; end
      rq.push_back(e);
      if (burst == 2'b01) a = a + 32'd4;
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    queue_read(id, addr, len, size, burst);
    send_ar(id, addr, len, size, burst);
    collect_r(int'(len) + 1, toggle, 1'b1);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready got awready=%b arready=%b want 1 1", awready, arready);
    end
    n_checks++;
    if ({wready, bvalid, rvalid, rlast} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_valid got wready/bvalid/rvalid/rlast=%b want 0000", {wready, bvalid, rvalid, rlast});
    end
    n_checks++;
    if ({bid, bresp, rid, rdata, rresp} !== 44'd0) begin
      n_errors++; $display("FAIL reset_data got bid=%0d bresp=%b rid=%0d rdata=%h rresp=%b want all 0", bid, bresp, rid, rdata, rresp);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_incr;
    do_write(4'd2, 32'h100, 4'd3, 4, 32'hA0, 4'hF, 3'd2, 2'b01, 0);
    do_read(4'd9, 32'h100, 4'd3, 3'd2, 2'b01, 1'b0);
  endtask

  task automatic test_strobe;
    do_write(4'd1, 32'h40, 4'd0, 1, 32'h1122_3344, 4'hF, 3'd2, 2'b01, 0);
    do_write(4'd1, 32'h40, 4'd0, 1, 32'hAABB_CCDD, 4'b0101, 3'd2, 2'b01, 0);
    do_read(4'd3, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0);
  endtask

  task automatic test_out_of_range;
    do_write(4'd4, 32'h0, 4'd0, 1, 32'h5A5A_0001, 4'hF, 3'd2, 2'b01, 0);
    do_write(4'd5, BASE + 32'(MEM_DEPTH * 4), 4'd0, 1, 32'hDEAD_BEEF, 4'hF, 3'd2, 2'b01, 0);
    do_read(4'd6, BASE + 32'(MEM_DEPTH * 4), 4'd0, 3'd2, 2'b01, 1'b0);
    do_read(4'd6, 32'h0, 4'd0, 3'd2, 2'b01, 1'b0);
    do_read(4'd7, 32'h0, 4'd0, 3'd0, 2'b01, 1'b0);
    do_write(4'd8, 32'h0, 4'd0, 1, 32'h0BAD_0000, 4'hF, 3'd2, 2'b10, 0);
    do_read(4'd6, 32'h0, 4'd0, 3'd2, 2'b01, 1'b0);
  endtask

  task automatic test_backpressure;
    do_write(4'd3, 32'h200, 4'd7, 8, 32'h2000_0000, 4'hF, 3'd2, 2'b01, 0);
    do_read(4'd11, 32'h200, 4'd7, 3'd2, 2'b01, 1'b1);
    do_write(4'd12, 32'h240, 4'd0, 1, 32'h0000_0240, 4'hF, 3'd2, 2'b01, 5);
  endtask

  task automatic test_wlast_errors;
    do_write(4'd1, 32'h300, 4'd5, 6, 32'h30, 4'hF, 3'd2, 2'b01, 0);
    do_write(4'd2, 32'h340, 4'd3, 2, 32'hB0, 4'hF, 3'd2, 2'b01, 0);
    do_write(4'd3, 32'h300, 4'd3, 6, 32'hC0, 4'hF, 3'd2, 2'b01, 0);
    do_read(4'd4, 32'h300, 4'd5, 3'd2, 2'b01, 1'b0);
  endtask

  task automatic test_fixed;
    do_write(4'd5, 32'h380, 4'd2, 3, 32'hF0, 4'hF, 3'd2, 2'b00, 0);
    do_read(4'd6, 32'h380, 4'd1, 3'd2, 2'b00, 1'b0);
  endtask

  task automatic test_concurrent;
    bexp_t e;
    do_write(4'd1, 32'h500, 4'd0, 1, 32'h1111_0000, 4'hF, 3'd2, 2'b01, 0);
    queue_read(4'd7, 32'h500, 4'd0, 3'd2, 2'b01);
    model[widx(32'h500)] = 32'h2222_0000;
    e.id = 4'd3; e.resp = 2'b00;
    bq.push_back(e);
    send_aw(4'd3, 32'h500, 4'd0, 3'd2, 2'b01);
    wdata = 32'h2222_0000; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'd7; araddr = 32'h500; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    n_checks++;
    if (wready !== 1'b1 || arready !== 1'b1) begin
      n_errors++; $display("FAIL concurrent_ready got wready=%b arready=%b want 1 1", wready, arready);
    end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    collect_r(1, 1'b0, 1'b1);
    collect_b(0);
    do_read(4'd8, 32'h500, 4'd0, 3'd2, 2'b01, 1'b0);
  endtask

  task automatic test_reset_mid_burst;
    queue_read(4'd2, 32'h200, 4'd7, 3'd2, 2'b01);
    send_ar(4'd2, 32'h200, 4'd7, 3'd2, 2'b01);
    collect_r(2, 1'b0, 1'b0);
    n_checks++;
    if (rvalid !== 1'b1) begin n_errors++; $display("FAIL midburst_active got rvalid=%b want 1", rvalid); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0) begin
      n_errors++; $display("FAIL midburst_abort got rvalid=%b rlast=%b want 0 0", rvalid, rlast);
    end
    rq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || rvalid !== 1'b0 || bvalid !== 1'b0) begin
      n_errors++; $display("FAIL after_reset got arready=%b awready=%b rvalid=%b bvalid=%b want 1 1 0 0",
                           arready, awready, rvalid, bvalid);
    end
    do_write(4'd9, 32'h600, 4'd1, 2, 32'h6000_0000, 4'hF, 3'd2, 2'b01, 0);
    do_read(4'd10, 32'h600, 4'd1, 3'd2, 2'b01, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) model[i] = '0;
    test_reset();
    test_incr();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_wlast_errors();
    test_fixed();
    test_concurrent();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
